// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM-like bus arbiter: FSM states, owner IDs and access sizes.
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_pick.sv
// Arbitration policy: data wins, but after STARVE_MAX data grants with fetch waiting, fetch is forced.
module sram_arb_pick
  import sram_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       inst_req_i,
  input  logic       data_req_i,
  input  logic [2:0] starve_cnt_i,
  output logic       grant_valid_o,
  output logic       grant_owner_o,
  output logic [2:0] starve_cnt_o
);

  always_comb begin
    grant_valid_o = inst_req_i | data_req_i;
    grant_owner_o = OWN_INST;
    starve_cnt_o  = starve_cnt_i;
    if (inst_req_i && data_req_i) begin
      if (starve_cnt_i < 3'(STARVE_MAX)) begin
        grant_owner_o = OWN_DATA;
        starve_cnt_o  = starve_cnt_i + 3'd1;
      end else begin
        starve_cnt_o = 3'd0;
      end
    end else if (data_req_i) begin
      grant_owner_o = OWN_DATA;
    end else if (inst_req_i) begin
      starve_cnt_o = 3'd0;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like master port between instruction fetch and data access,
// one outstanding transaction at a time.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  state_t        state_q;
  logic          owner_q;
  logic [2:0]    starve_q;
  logic          bus_req_q;
  logic          bus_wr_q;
  logic [1:0]    bus_size_q;
  logic [AW-1:0] bus_addr_q;
  logic [DW-1:0] bus_wdata_q;
  logic [DW-1:0] inst_rdata_q;
  logic [DW-1:0] data_rdata_q;

  logic          grant_valid;
  logic          grant_owner;
  logic [2:0]    starve_d;
  logic          addr_hs;
  logic          data_hs;

  sram_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .inst_req_i   (inst_req),
    .data_req_i   (data_req),
    .starve_cnt_i (starve_q),
    .grant_valid_o(grant_valid),
    .grant_owner_o(grant_owner),
    .starve_cnt_o (starve_d)
  );

  // Handshakes are suppressed during reset so an abandoned transaction never leaks a pulse.
  assign addr_hs = !rst && (state_q == ST_ADDR) && bus_addr_ok;
  assign data_hs = !rst && (state_q == ST_DATA) && bus_data_ok;

  assign inst_addr_ok = addr_hs && (owner_q == OWN_INST);
  assign data_addr_ok = addr_hs && (owner_q == OWN_DATA);
  assign inst_data_ok = data_hs && (owner_q == OWN_INST);
  assign data_data_ok = data_hs && (owner_q == OWN_DATA);

  assign inst_rdata = inst_data_ok ? bus_rdata : inst_rdata_q;
  assign data_rdata = data_data_ok ? bus_rdata : data_rdata_q;

  assign bus_req   = bus_req_q;
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      starve_q     <= 3'd0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= 2'd0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            state_q   <= ST_ADDR;
            owner_q   <= grant_owner;
            starve_q  <= starve_d;
            bus_req_q <= 1'b1;
            if (grant_owner == OWN_DATA) begin
              bus_wr_q    <= data_wr;
              bus_size_q  <= data_size;
              bus_addr_q  <= data_addr;
              bus_wdata_q <= data_wdata;
            end else begin
              bus_wr_q    <= 1'b0;
              bus_size_q  <= SZ_WORD;
              bus_addr_q  <= inst_addr;
              bus_wdata_q <= '0;
            end
          end
        end
        ST_ADDR: begin
          if (bus_addr_ok) begin
            state_q   <= ST_DATA;
            bus_req_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (bus_data_ok) begin
            state_q <= ST_IDLE;
            if (owner_q == OWN_DATA) data_rdata_q <= bus_rdata;
            else                     inst_rdata_q <= bus_rdata;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_sram_bus_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata   = 32'h0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.STARVE_MAX(SMAX), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave configuration (written by the test) and slave-side view of handshakes.
  int          addr_wait = 0, data_wait = 0;
  logic [31:0] slave_rdata = 32'h0;
  bit          spurious = 0;
  bit          snap_rst = 0, snap_aacc = 0, snap_dacc = 0;
  int          aw_cnt = 0, dw_cnt = 0;
  bit          s_in_data = 0;

  always @(posedge clk) begin
    #2;
    if (snap_rst) begin
      s_in_data = 0; aw_cnt = 0; dw_cnt = 0;
    end else if (snap_aacc) begin
      s_in_data = 1; aw_cnt = 0; dw_cnt = 0;
    end else if (snap_dacc && s_in_data) begin
      s_in_data = 0; dw_cnt = 0;
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = spurious;
    if (!s_in_data && bus_req) begin
      if (aw_cnt >= addr_wait) bus_addr_ok = 1'b1;
      else aw_cnt++;
    end
    if (s_in_data) begin
      if (dw_cnt >= data_wait) bus_data_ok = 1'b1;
      else dw_cnt++;
    end
    bus_rdata = slave_rdata;
  end

  // Transaction-level model of the arbiter.
  bit          m_active = 0, m_acc = 0, m_owner = 0;
  int          m_consec = 0;
  logic        m_wr = 0;
  logic [1:0]  m_size = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_irdata = 0, m_drdata = 0;
  bit          chk_en = 0;

  // Observation logs (monotonic).
  int          n_iaok = 0, n_idok = 0, n_daok = 0, n_ddok = 0, n_req_d4 = 0;
  int          c_iaok = 0, c_idok = 0, c_daok = 0, c_ddok = 0, c_rise = 0;
  logic        prev_breq = 0;
  logic        cap_wr = 0;
  logic [1:0]  cap_size = 0;
  logic [31:0] cap_addr = 0, cap_wdata = 0;
  string       glog = "";
  bit          iaok_seen = 0, daok_seen = 0;
  bit          inst_one_shot = 1, data_one_shot = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic sample();
    logic breq, e_iaok, e_daok, e_idok, e_ddok;
    breq   = m_active && !m_acc;
    e_iaok = !rst && breq && !m_owner && bus_addr_ok;
    e_daok = !rst && breq &&  m_owner && bus_addr_ok;
    e_idok = !rst && m_active && m_acc && !m_owner && bus_data_ok;
    e_ddok = !rst && m_active && m_acc &&  m_owner && bus_data_ok;
    if (chk_en) begin
      chk("bus_req", bus_req, breq);
      chk("bus_wr", bus_wr, m_wr);
      chk("bus_size", bus_size, m_size);
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("inst_addr_ok", inst_addr_ok, e_iaok);
      chk("data_addr_ok", data_addr_ok, e_daok);
      chk("inst_data_ok", inst_data_ok, e_idok);
      chk("data_data_ok", data_data_ok, e_ddok);
      chk("inst_rdata", inst_rdata, e_idok ? bus_rdata : m_irdata);
      chk("data_rdata", data_rdata, e_ddok ? bus_rdata : m_drdata);
    end
    if (inst_addr_ok || data_addr_ok) begin
      cap_wr = bus_wr; cap_size = bus_size; cap_addr = bus_addr; cap_wdata = bus_wdata;
    end
    if (inst_addr_ok) begin n_iaok++; c_iaok = cyc; glog = {glog, "I"}; iaok_seen = 1; end
    if (data_addr_ok) begin n_daok++; c_daok = cyc; glog = {glog, "D"}; daok_seen = 1; end
    if (inst_data_ok) begin n_idok++; c_idok = cyc; end
    if (data_data_ok) begin n_ddok++; c_ddok = cyc; end
    if (bus_req && !prev_breq) c_rise = cyc;
    if (bus_req && bus_addr == 32'h80001004) n_req_d4++;
    prev_breq = bus_req;
    snap_rst  = rst;
    snap_aacc = !rst && bus_req && bus_addr_ok;
    snap_dacc = !rst && bus_data_ok;
    // Advance the model to what the next rising edge must produce.
    if (rst) begin
      m_active = 0; m_acc = 0; m_owner = 0; m_consec = 0;
      m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
    end else if (!m_active) begin
      if (data_req && !(inst_req && m_consec >= SMAX)) begin
        if (inst_req) m_consec++;
        m_owner = 1; m_wr = data_wr; m_size = data_size; m_addr = data_addr; m_wdata = data_wdata;
        m_active = 1; m_acc = 0;
      end else if (inst_req) begin
        m_consec = 0;
        m_owner = 0; m_wr = 0; m_size = 2'd2; m_addr = inst_addr; m_wdata = 0;
        m_active = 1; m_acc = 0;
      end
    end else if (!m_acc) begin
      if (bus_addr_ok) m_acc = 1;
    end else if (bus_data_ok) begin
      m_active = 0;
      if (m_owner) m_drdata = bus_rdata;
      else         m_irdata = bus_rdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (iaok_seen) begin
      if (inst_one_shot) inst_req = 1'b0;
      iaok_seen = 0;
    end
    if (daok_seen) begin
      if (data_one_shot) data_req = 1'b0;
      daok_seen = 0;
    end
  endtask

  int t0, b_ia, b_id, b_da, b_dd, gl0, nd0;

  task automatic bases();
    b_ia = n_iaok; b_id = n_idok; b_da = n_daok; b_dd = n_ddok; gl0 = glog.len();
  endtask

  initial begin
    rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
    data_size = 0; data_addr = 0; data_wdata = 0;
    tick(); tick();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk_en = 1;
    rst = 0;
    tick();

    // Inst-only fetch, zero-wait slave
    addr_wait = 0; data_wait = 0; slave_rdata = 32'h3C080001;
    bases();
    inst_addr = 32'hBFC00000; inst_req = 1; t0 = cyc;
    for (int k = 0; k < 20 && n_idok == b_id; k++) tick();
    tick(); tick();
    chk("t1_done", n_idok - b_id, 1);
    chk("t1_aok_lat", c_iaok - t0, 1);
    chk("t1_dok_lat", c_idok - t0, 2);
    chk("t1_bus_addr", cap_addr, 32'hBFC00000);
    chk("t1_bus_wr", cap_wr, 0);
    chk("t1_bus_size", cap_size, 2);
    chk("t1_rdata", inst_rdata, 32'h3C080001);
    chk("t1_no_data_pulse", (n_daok - b_da) + (n_ddok - b_dd), 0);

    // Simultaneous inst + data load, slave addr_ok delayed 3 cycles
    addr_wait = 3; slave_rdata = 32'hA5A50001;
    bases(); nd0 = n_req_d4;
    data_addr = 32'h80001004; data_size = 2; data_wr = 0; data_wdata = 0; data_req = 1;
    inst_addr = 32'hBFC00004; inst_req = 1;
    for (int k = 0; k < 60 && n_idok == b_id; k++) tick();
    tick(); tick();
    chk("t2_done", n_idok - b_id, 1);
    chk("t2_order", glog.substr(gl0, gl0 + 1) == "DI", 1);
    chk("t2_addr_cycles", n_req_d4 - nd0, 4);
    chk("t2_inst_grant", c_rise - c_ddok, 2);
    chk("t2_data_rdata", data_rdata, 32'hA5A50001);

    // Byte store, data_ok five cycles after address acceptance
    addr_wait = 2; data_wait = 4; slave_rdata = 32'h0;
    bases();
    data_wr = 1; data_size = 0; data_addr = 32'h80000003; data_wdata = 32'h000000AB; data_req = 1;
    for (int k = 0; k < 40 && n_ddok == b_dd; k++) tick();
    tick(); tick();
    chk("t3_done", n_ddok - b_dd, 1);
    chk("t3_no_inst_dok", n_idok - b_id, 0);
    chk("t3_dok_delay", c_ddok - c_daok, 5);
    chk("t3_wr", cap_wr, 1);
    chk("t3_size", cap_size, 0);
    chk("t3_addr", cap_addr, 32'h80000003);
    chk("t3_wdata", cap_wdata, 32'h000000AB);
    data_wr = 0;

    // Starvation guard with both requests held continuously
    addr_wait = 0; data_wait = 0; slave_rdata = 32'h00C0FFEE;
    bases();
    inst_one_shot = 0; data_one_shot = 0;
    inst_addr = 32'hBFC00100; data_addr = 32'h80002000; data_size = 2;
    inst_req = 1; data_req = 1;
    for (int k = 0; k < 80 && (glog.len() - gl0) < 10; k++) tick();
    inst_req = 0; data_req = 0;
    inst_one_shot = 1; data_one_shot = 1;
    repeat (6) tick();
    chk("t4_grant_seq", glog.substr(gl0, gl0 + 9) == "DDDDIDDDDI", 1);

    // Reset while in DATA, then spurious bus_data_ok
    addr_wait = 0; data_wait = 10; slave_rdata = 32'h77777777;
    bases();
    inst_addr = 32'hBFC00008; inst_req = 1;
    for (int k = 0; k < 20 && n_iaok == b_ia; k++) tick();
    tick();
    rst = 1;
    tick();
    chk("t5_rst_bus_req", bus_req, 0);
    chk("t5_rst_bus_addr", bus_addr, 0);
    chk("t5_rst_bus_size", bus_size, 0);
    chk("t5_rst_inst_rdata", inst_rdata, 0);
    chk("t5_rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    rst = 0; spurious = 1;
    bases();
    repeat (3) tick();
    spurious = 0;
    tick();
    chk("t5_no_pulse_after_rst", (n_idok - b_id) + (n_ddok - b_dd), 0);
    data_wait = 0; slave_rdata = 32'h11112222;
    inst_addr = 32'hBFC00010; inst_req = 1;
    for (int k = 0; k < 20 && n_idok == b_id; k++) tick();
    tick();
    chk("t5_fresh_done", n_idok - b_id, 1);
    chk("t5_fresh_rdata", inst_rdata, 32'h11112222);
    chk("t5_fresh_lat", c_idok - c_iaok, 1);

    // Spurious bus_data_ok in IDLE and in ADDR
    bases();
    spurious = 1;
    tick(); tick();
    spurious = 0;
    tick();
    chk("t6_idle_no_pulse", (n_idok - b_id) + (n_ddok - b_dd), 0);
    chk("t6_idle_bus_req", bus_req, 0);
    addr_wait = 4; slave_rdata = 32'h5A5A0006;
    inst_addr = 32'hBFC00020; inst_req = 1;
    tick();
    spurious = 1;
    tick(); tick();
    spurious = 0;
    chk("t6_addr_no_pulse", n_idok - b_id, 0);
    chk("t6_still_addr", bus_req, 1);
    for (int k = 0; k < 30 && n_idok == b_id; k++) tick();
    tick();
    chk("t6_done", n_idok - b_id, 1);
    chk("t6_rdata", inst_rdata, 32'h5A5A0006);
    chk("t6_no_data_pulse", (n_daok - b_da) + (n_ddok - b_dd), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
